// File: rtl/demux_router_1to4.sv
// rtl/demux_router_1to4.sv - buffered 1-to-4 valid/ready router with 2-entry FIFO and per-port delivery counters
module demux_router_1to4 #(
    parameter int WORD_LENGTH = 32,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_sel,
    input  logic [WORD_LENGTH-1:0]   in_data,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic [WORD_LENGTH-1:0]   out_data,
    input  logic                     count_clr,
    output logic [4*COUNT_WIDTH-1:0] delivered,
    output logic [1:0]               occupancy
);

    logic [1:0]             sel_q  [2];
    logic [WORD_LENGTH-1:0] data_q [2];

    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             occ_q, occ_d;
    logic [COUNT_WIDTH-1:0] cnt_q [4];
    logic [COUNT_WIDTH-1:0] cnt_d [4];

    logic       push;
    logic       pop;
    logic [1:0] head_sel;

    // Ready depends only on registered occupancy so sinks never gate the producer combinationally.
    assign in_ready  = (occ_q != 2'd2);
    assign push      = in_valid && in_ready;
    assign head_sel  = sel_q[rd_ptr_q];
    assign out_data  = data_q[rd_ptr_q];
    assign occupancy = occ_q;

    always_comb begin
        out_valid = 4'b0000;
        if (occ_q != 2'd0) begin
            out_valid[head_sel] = 1'b1;
        end
    end

    assign pop = |(out_valid & out_ready);

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // A clear wins over a same-cycle delivery, so that delivery is never counted.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (count_clr) begin
                cnt_d[i] = '0;
            end else if (pop && (head_sel == 2'(i))) begin
                cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            delivered[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Payload storage carries no reset; entries are only observable once occupancy says so.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_q[wr_ptr_q]  <= in_sel;
            data_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_demux_router_1to4.sv
// tb/tb_demux_router_1to4.sv - randomized scoreboard bench for demux_router_1to4
module tb_demux_router_1to4;

    localparam int W  = 32;
    localparam int CW = 8;

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } item_t;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_sel;
    logic [W-1:0]    in_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [W-1:0]    out_data;
    logic            count_clr;
    logic [4*CW-1:0] delivered;
    logic [1:0]      occupancy;

    item_t         mq[$];
    logic [CW-1:0] cnt [4];
    int            tests;
    int            fails;
    bit            mon_en;
    bit            sink_rand;

    demux_router_1to4 #(.WORD_LENGTH(W), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count_clr (count_clr),
        .delivered (delivered),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word queue plus per-port counters, advanced by observed handshakes.
    always @(negedge clk) begin : monitor
        logic [3:0]      ev;
        logic [4*CW-1:0] edl;
        logic [1:0]      p;
        if (mon_en) begin
            ev = (mq.size() != 0) ? (4'b0001 << mq[0].sel) : 4'b0000;
            for (int i = 0; i < 4; i++) edl[i*CW +: CW] = cnt[i];
            chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            chk("occupancy", 64'(occupancy), 64'(mq.size()));
            chk("out_valid", 64'(out_valid), 64'(ev));
            if (ev != 4'b0000) chk("out_data", 64'(out_data), 64'(mq[0].data));
            chk("delivered", 64'(delivered), 64'(edl));
            if (!reset) begin
                mq.delete();
                for (int i = 0; i < 4; i++) cnt[i] = '0;
            end else begin
                if ((ev & out_ready) != 4'b0000) begin
                    p = mq[0].sel;
                    void'(mq.pop_front());
                    if (!count_clr) cnt[p] = cnt[p] + 1'b1;
                end
                if (count_clr) begin
                    for (int i = 0; i < 4; i++) cnt[i] = '0;
                end
            end
        end
    end

    always begin : sink
        @(posedge clk);
        #1;
        if (sink_rand) out_ready = 4'($urandom);
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid low.
    task automatic send(input logic [1:0] s, input logic [W-1:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready && reset;
            #1;
            if (acc) mq.push_back('{s, d});
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted sel=%0d data=%0h", s, d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq.size() != 0 && n < 500) begin
            idle(1);
            n++;
        end
        tests++;
        if (mq.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout actual=%0d expected=0", mq.size());
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        mon_en    = 1'b0;
        sink_rand = 1'b0;
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 4'b0000;
        count_clr = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = '0;

        // Reset held with in_valid high: nothing may be accepted.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);
        in_valid = 1'b0;
        reset    = 1'b1;
        idle(2);

        // Routing one word to each port.
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) send(2'(i), 32'hA0 + 32'(i));
        drain();
        idle(1);
        chk("routing_delivered", 64'(delivered), 64'h01010101);

        // Backpressure and full.
        out_ready = 4'b0000;
        send(2'd2, 32'hB0);
        send(2'd2, 32'hB1);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_occupancy", 64'(occupancy), 64'd2);
        @(posedge clk);
        #1;
        fork
            send(2'd2, 32'hB2);
            begin
                idle(3);
                out_ready = 4'b0100;
            end
        join
        drain();

        // Head-of-line blocking.
        out_ready = 4'b1101;
        send(2'd1, 32'hC0);
        send(2'd0, 32'hC1);
        idle(5);
        @(negedge clk);
        chk("hol_out_valid", 64'(out_valid), 64'b0010);
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        drain();

        // Randomized traffic with random sink stalls.
        sink_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(3) == 0) idle(1);
            send(2'($urandom), $urandom);
        end
        drain();
        sink_rand = 1'b0;
        idle(1);
        out_ready = 4'b1111;

        // Counter wrap on port 3.
        count_clr = 1'b1;
        idle(1);
        count_clr = 1'b0;
        for (int k = 0; k < 256; k++) send(2'd3, 32'(k));
        drain();
        idle(1);
        chk("wrap_delivered", 64'(delivered), 64'd0);

        // Clear during a delivery cycle wins over the increment.
        send(2'd0, 32'hE0);
        drain();
        out_ready = 4'b0000;
        idle(1);
        send(2'd3, 32'hD0);
        count_clr = 1'b1;
        out_ready = 4'b1000;
        idle(1);
        count_clr = 1'b0;
        out_ready = 4'b1111;
        @(negedge clk);
        chk("clr_delivered", 64'(delivered), 64'd0);
        chk("clr_occupancy", 64'(occupancy), 64'd0);
        @(posedge clk);
        #1;

        // Reset while full discards both words.
        out_ready = 4'b0000;
        send(2'd1, 32'hF0);
        send(2'd2, 32'hF1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        out_ready = 4'b1111;
        @(negedge clk);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        idle(4);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
